ts_sync_finder: RTL and testbench

Parametrised transport-stream packet synchroniser for the T2-MI packer input path, placed between the byte-wide TS receiver and the packet buffer. It hunts for the sync byte and confirms it over a configurable number of packets. It detects 188- or 204-byte packet length, freewheels across a configurable number of corrupted sync bytes, and delivers a one-cycle-delayed byte stream with packet-start and byte-index markers.

---
 rtl/ts_sync_pkg.sv | 19 +
 rtl/ts_sync_finder.sv | 193 +++++++++++++++++++
 tb/tb_ts_sync_finder.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_sync_pkg.sv
// rtl/ts_sync_pkg.sv - shared types and constants for the TS packet synchroniser
package ts_sync_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int         TS_LEN_188  = 188;
  localparam int         TS_LEN_204  = 204;
  localparam logic [7:0] TS_SYNC     = 8'h47;
  localparam logic [7:0] TS_SYNC_INV = 8'hB8;

  localparam int LEN_FIXED_188 = 0;
  localparam int LEN_FIXED_204 = 1;
  localparam int LEN_AUTO      = 2;

endpackage

// File: rtl/ts_sync_finder.sv
// rtl/ts_sync_finder.sv - TS sync hunt/verify/lock with 188/204 length detection
// Outputs are registered and aligned with the one-cycle-delayed byte stream.
module ts_sync_finder
  import ts_sync_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = TS_SYNC,
  parameter int         ACCEPT_INV = 0,
  parameter int         LOCK_CNT   = 5,
  parameter int         UNLOCK_CNT = 2,
  parameter int         LEN_MODE   = LEN_AUTO
) (
  input  logic       dclk_i,
  input  logic       rst_n_i,
  input  logic [7:0] data_in_i,
  input  logic       dvalid_i,
  output logic [7:0] data_out_o,
  output logic       dvalid_out_o,
  output logic       psync_o,
  output logic [7:0] byte_index_o,
  output logic       sync_found_o,
  output logic       pkt_204_o,
  output logic       sync_lost_o
);

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);
  localparam logic [7:0] L188     = 8'(TS_LEN_188);
  localparam logic [7:0] L204     = 8'(TS_LEN_204);

  state_e     state_q, state_d;
  logic [7:0] pos_q, pos_d;
  logic [3:0] good_q, good_d;
  logic [3:0] miss_q, miss_d;
  logic       len_known_q, len_known_d;
  logic       len204_q, len204_d;

  logic [7:0] data_out_q;
  logic       dvalid_out_q;
  logic       psync_q, psync_d;
  logic [7:0] byte_index_q, byte_index_d;
  logic       sync_found_q, sync_found_d;
  logic       sync_lost_q, sync_lost_d;

  logic       is_match;
  logic       len_det;
  logic [7:0] len_w;
  logic [3:0] good_inc;
  logic [3:0] miss_inc;
  logic       at_check;

  assign is_match = (data_in_i == SYNC_BYTE) ||
                    ((ACCEPT_INV != 0) && (data_in_i == TS_SYNC_INV));
  assign len_det  = (LEN_MODE != LEN_AUTO) || len_known_q;
  assign len_w    = (LEN_MODE == LEN_FIXED_204) ? L204 :
                    (LEN_MODE == LEN_FIXED_188) ? L188 :
                    (len204_q ? L204 : L188);
  assign good_inc = good_q + 4'd1;
  assign miss_inc = miss_q + 4'd1;
  // Undetermined auto length checks both candidate positions; 188 wins if both could match.
  assign at_check = len_det ? (pos_q == len_w) : ((pos_q == L188) || (pos_q == L204));

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    good_d       = good_q;
    miss_d       = miss_q;
    len_known_d  = len_known_q;
    len204_d     = len204_q;
    psync_d      = 1'b0;
    byte_index_d = byte_index_q;
    sync_found_d = sync_found_q;
    sync_lost_d  = 1'b0;

    if (dvalid_i) begin
      case (state_q)
        HUNT: begin
          byte_index_d = 8'd0;
          sync_found_d = 1'b0;
          if (is_match) begin
            pos_d   = 8'd1;
            good_d  = 4'd1;
            state_d = VERIFY;
          end
        end

        VERIFY: begin
          byte_index_d = 8'd0;
          sync_found_d = 1'b0;
          if (at_check) begin
            if (is_match) begin
              good_d = good_inc;
              pos_d  = 8'd1;
              if (!len_det) begin
                len_known_d = 1'b1;
                len204_d    = (pos_q == L204);
              end
              if (good_inc == LOCK_C) begin
                state_d      = LOCKED;
                miss_d       = 4'd0;
                sync_found_d = 1'b1;
                psync_d      = 1'b1;
              end
            end else if (!len_det && (pos_q == L188)) begin
              pos_d = pos_q + 8'd1;
            end else begin
              state_d     = HUNT;
              pos_d       = 8'd0;
              good_d      = 4'd0;
              len_known_d = 1'b0;
              len204_d    = 1'b0;
            end
          end else begin
            pos_d = pos_q + 8'd1;
          end
        end

        LOCKED: begin
          sync_found_d = 1'b1;
          byte_index_d = pos_q;
          if (pos_q == 8'd0) begin
            pos_d = 8'd1;
            if (is_match) begin
              miss_d  = 4'd0;
              psync_d = 1'b1;
            end else if (miss_inc < UNLOCK_C) begin
              miss_d  = miss_inc;
              psync_d = 1'b1;
            end else begin
              state_d      = HUNT;
              pos_d        = 8'd0;
              good_d       = 4'd0;
              miss_d       = 4'd0;
              len_known_d  = 1'b0;
              len204_d     = 1'b0;
              sync_found_d = 1'b0;
              sync_lost_d  = 1'b1;
              byte_index_d = 8'd0;
            end
          end else begin
            pos_d = (pos_q == len_w - 8'd1) ? 8'd0 : pos_q + 8'd1;
          end
        end

        default: begin
          state_d = HUNT;
          pos_d   = 8'd0;
          good_d  = 4'd0;
          miss_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge dclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= HUNT;
      pos_q        <= 8'd0;
      good_q       <= 4'd0;
      miss_q       <= 4'd0;
      len_known_q  <= 1'b0;
      len204_q     <= 1'b0;
      data_out_q   <= 8'd0;
      dvalid_out_q <= 1'b0;
      psync_q      <= 1'b0;
      byte_index_q <= 8'd0;
      sync_found_q <= 1'b0;
      sync_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      good_q       <= good_d;
      miss_q       <= miss_d;
      len_known_q  <= len_known_d;
      len204_q     <= len204_d;
      data_out_q   <= data_in_i;
      dvalid_out_q <= dvalid_i;
      psync_q      <= psync_d;
      byte_index_q <= byte_index_d;
      sync_found_q <= sync_found_d;
      sync_lost_q  <= sync_lost_d;
    end
  end

  assign data_out_o   = data_out_q;
  assign dvalid_out_o = dvalid_out_q;
  assign psync_o      = psync_q;
  assign byte_index_o = byte_index_q;
  assign sync_found_o = sync_found_q;
  assign sync_lost_o  = sync_lost_q;
  assign pkt_204_o    = (LEN_MODE == LEN_FIXED_204) ? 1'b1 :
                        (LEN_MODE == LEN_AUTO) ? (len_known_q & len204_q) : 1'b0;

endmodule

// File: tb/tb_ts_sync_finder.sv
// tb/tb_ts_sync_finder.sv - self-checking bench for ts_sync_finder
// Three instances: auto length, auto length with inverted sync, fixed 204.
module tb_ts_sync_finder;

  localparam int LOCK   = 5;
  localparam int UNLOCK = 2;
  localparam int MAXN   = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] din = 8'd0;
  logic dv = 1'b0;

  wire [7:0] o_dout [3];
  wire [7:0] o_idx  [3];
  wire [2:0] o_dv, o_psync, o_found, o_p204, o_lost;

  always #5 clk = ~clk;

  ts_sync_finder dut_a (
    .dclk_i(clk), .rst_n_i(rst_n), .data_in_i(din), .dvalid_i(dv),
    .data_out_o(o_dout[0]), .dvalid_out_o(o_dv[0]), .psync_o(o_psync[0]),
    .byte_index_o(o_idx[0]), .sync_found_o(o_found[0]), .pkt_204_o(o_p204[0]),
    .sync_lost_o(o_lost[0]));

  ts_sync_finder #(.ACCEPT_INV(1)) dut_i (
    .dclk_i(clk), .rst_n_i(rst_n), .data_in_i(din), .dvalid_i(dv),
    .data_out_o(o_dout[1]), .dvalid_out_o(o_dv[1]), .psync_o(o_psync[1]),
    .byte_index_o(o_idx[1]), .sync_found_o(o_found[1]), .pkt_204_o(o_p204[1]),
    .sync_lost_o(o_lost[1]));

  ts_sync_finder #(.LEN_MODE(1)) dut_f (
    .dclk_i(clk), .rst_n_i(rst_n), .data_in_i(din), .dvalid_i(dv),
    .data_out_o(o_dout[2]), .dvalid_out_o(o_dv[2]), .psync_o(o_psync[2]),
    .byte_index_o(o_idx[2]), .sync_found_o(o_found[2]), .pkt_204_o(o_p204[2]),
    .sync_lost_o(o_lost[2]));

  int nchk = 0;
  int nerr = 0;
  int n = 0;
  bit chk_f = 1'b0;
  logic [7:0] sb [MAXN];
  bit ef [3][MAXN];
  bit ep [3][MAXN];
  bit el [3][MAXN];
  bit e204 [3][MAXN];
  logic [7:0] ei [3][MAXN];

  task automatic chk(input string tag, input int d, input int k,
                     input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s dut%0d byte%0d observed=%0d expected=%0d", tag, d, k, obs, exp);
    end
  endtask

  function automatic bit sm(input logic [7:0] v, input bit inv);
    return (v == 8'h47) || (inv && v == 8'hB8);
  endfunction

  function automatic logic [7:0] payload();
    logic [7:0] v;
    do v = 8'($urandom); while (v == 8'h47 || v == 8'hB8);
    return v;
  endfunction

  task automatic push_pkt(input int len, input logic [7:0] s);
    sb[n] = s;
    n++;
    for (int i = 1; i < len; i++) begin
      sb[n] = payload();
      n++;
    end
  endtask

  task automatic push_junk(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      sb[n] = payload();
      n++;
    end
  endtask

  // Scan the whole recorded stream: find a candidate, look ahead at the
  // packet-length spaced check points, then walk the locked region.
  task automatic model(input int d, input int mode, input bit inv);
    int k, c, len, fail, p0, miss, q, cp, endj;
    for (int j = 0; j < n; j++) begin
      ef[d][j] = 0; ep[d][j] = 0; el[d][j] = 0; ei[d][j] = 8'd0;
      e204[d][j] = (mode == 1);
    end
    k = 0;
    while (k < n) begin
      if (!sm(sb[k], inv)) begin
        k++;
        continue;
      end
      c = k; fail = -1; len = 0;
      if (mode == 0) len = 188;
      else if (mode == 1) len = 204;
      else if (c + 188 < n && sm(sb[c + 188], inv)) len = 188;
      else if (c + 204 >= n) begin
        k = n;
        continue;
      end
      else if (sm(sb[c + 204], inv)) len = 204;
      else fail = c + 204;
      if (fail < 0) begin
        for (int g = 1; g < LOCK && fail < 0; g++) begin
          cp = c + g * len;
          if (cp >= n) fail = n;
          else if (!sm(sb[cp], inv)) fail = cp;
        end
      end
      if (fail >= 0) begin
        if (mode == 2 && len != 0)
          for (int j = c + len; j < fail && j < n; j++) e204[d][j] = (len == 204);
        k = fail + 1;
        continue;
      end
      p0 = c + (LOCK - 1) * len;
      miss = 0;
      endj = n;
      for (int j = p0; j < n; j++) begin
        q = (j - c) % len;
        if (q == 0 && j != p0) begin
          if (sm(sb[j], inv)) miss = 0;
          else miss++;
          if (miss == UNLOCK) begin
            el[d][j] = 1;
            endj = j;
            break;
          end
        end
        ef[d][j] = 1;
        ei[d][j] = 8'(q);
        ep[d][j] = (q == 0);
      end
      if (mode == 2)
        for (int j = c + len; j < endj; j++) e204[d][j] = (len == 204);
      k = endj + 1;
    end
  endtask

  task automatic build_models();
    model(0, 2, 1'b0);
    model(1, 2, 1'b1);
    model(2, 1, 1'b0);
  endtask

  task automatic check_reset(input int tagk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_found", d, tagk, 32'(o_found[d]), 0);
      chk("rst_psync", d, tagk, 32'(o_psync[d]), 0);
      chk("rst_idx",   d, tagk, 32'(o_idx[d]), 0);
      chk("rst_lost",  d, tagk, 32'(o_lost[d]), 0);
      chk("rst_dout",  d, tagk, 32'(o_dout[d]), 0);
      chk("rst_dv",    d, tagk, 32'(o_dv[d]), 0);
      chk("rst_p204",  d, tagk, 32'(o_p204[d]), (d == 2) ? 1 : 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    dv = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset(-1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input bit gaps, input int rst_at);
    int k, cyc, nd;
    logic v;
    logic [7:0] d;
    k = 0;
    cyc = 0;
    nd = chk_f ? 3 : 2;
    while (k < n) begin
      @(negedge clk);
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      d = v ? sb[k] : 8'($urandom);
      din = d;
      dv = v;
      @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
        chk("dvalid_out", u, k, 32'(o_dv[u]), 32'(v));
        chk("data_out", u, k, 32'(o_dout[u]), 32'(d));
      end
      for (int u = 0; u < nd; u++) begin
        if (v) begin
          chk("sync_found", u, k, 32'(o_found[u]), 32'(ef[u][k]));
          chk("psync", u, k, 32'(o_psync[u]), 32'(ep[u][k]));
          chk("sync_lost", u, k, 32'(o_lost[u]), 32'(el[u][k]));
          chk("pkt_204", u, k, 32'(o_p204[u]), 32'(e204[u][k]));
          if (ef[u][k]) chk("byte_index", u, k, 32'(o_idx[u]), 32'(ei[u][k]));
        end else begin
          chk("psync_gap", u, k, 32'(o_psync[u]), 0);
          chk("lost_gap", u, k, 32'(o_lost[u]), 0);
        end
      end
      if (v) k++;
      if (rst_at >= 0 && k == rst_at) begin
        #3;
        dv = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset(k);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      cyc++;
      if (cyc > 20000) begin
        nchk++;
        nerr++;
        $error("FAIL run_timeout cycles=%0d bytes=%0d of %0d", cyc, k, n);
        break;
      end
    end
  endtask

  initial begin
    // Clean 188 stream from reset.
    do_reset();
    n = 0;
    for (int p = 0; p < 8; p++) push_pkt(188, 8'h47);
    build_models();
    run(1'b0, -1);

    // 204 stream: auto detection and fixed-204 instance.
    do_reset();
    n = 0;
    chk_f = 1'b1;
    for (int p = 0; p < 8; p++) push_pkt(204, 8'h47);
    build_models();
    run(1'b0, -1);
    chk_f = 1'b0;

    // Single corrupted sync, then two consecutive: unlock and re-hunt.
    do_reset();
    n = 0;
    for (int p = 0; p < 12; p++) push_pkt(188, (p == 6 || p == 8 || p == 9) ? 8'h00 : 8'h47);
    build_models();
    run(1'b0, -1);

    // Stray sync byte ahead of the true alignment.
    do_reset();
    n = 0;
    push_junk(50);
    sb[n] = 8'h47;
    n++;
    push_junk(49);
    for (int p = 0; p < 8; p++) push_pkt(188, 8'h47);
    build_models();
    run(1'b0, -1);

    // Random 50% DVALID gaps.
    do_reset();
    n = 0;
    for (int p = 0; p < 8; p++) push_pkt(188, 8'h47);
    build_models();
    run(1'b1, -1);

    // Asynchronous reset mid-packet while locked, then relock on a fresh stream.
    do_reset();
    n = 0;
    for (int p = 0; p < 8; p++) push_pkt(188, 8'h47);
    build_models();
    run(1'b0, 5 * 188 + 60);
    n = 0;
    push_junk(30);
    for (int p = 0; p < 7; p++) push_pkt(188, 8'h47);
    build_models();
    run(1'b0, -1);

    // Inverted sync every 8th packet plus one corrupted sync right after it.
    do_reset();
    n = 0;
    for (int p = 0; p < 16; p++)
      push_pkt(188, (p % 8 == 7) ? 8'hB8 : (p == 8) ? 8'h00 : 8'h47);
    build_models();
    run(1'b1, -1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
